mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single external memory port between the instruction-cache refill interface and the data-memory interface of an ARVI hart.
- Sits between the core's IC/DM ports and the system memory.
- Round-robin grant; the DM side can lock the port across an atomic read-modify-write sequence.
- Replaces separate IM/DM buses so a single-ported memory can back one core.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_rr_grant2.sv | 26 ++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IC/DM memory-port arbiter: arbiter states,
// default data width and the funct3 used for instruction refills.
package mem_port_arbiter_pkg;

   localparam int unsigned XLEN    = 32;
   localparam logic [2:0]  F3_WORD = 3'b010;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_IC   = 2'd1,
      ARB_DM   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_grant2.sv
// Two-way round-robin picker. 'last' = 1 means side B was granted last,
// so A wins a tie; lock_b reserves the grant for side B only.
module rr_grant2 (
   input  logic req_a,
   input  logic req_b,
   input  logic last,
   input  logic lock_b,
   output logic gnt_a,
   output logic gnt_b
);

   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (lock_b) begin
         gnt_b = req_b;
      end else if (req_a && req_b) begin
         gnt_a = last;
         gnt_b = !last;
      end else begin
         gnt_a = req_a;
         gnt_b = req_b;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the IC refill and DM interfaces of a hart:
// round-robin grant, DM lock for atomics, registered memory-side request.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned XLEN          = mem_port_arbiter_pkg::XLEN,
   parameter bit          RESET_LAST_DM = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_ic_req,
   input  logic [XLEN-1:0] i_ic_addr,
   output logic            o_ic_ready,
   output logic [XLEN-1:0] o_ic_rdata,
   input  logic            i_dm_rd,
   input  logic            i_dm_wr,
   input  logic [XLEN-1:0] i_dm_addr,
   input  logic [XLEN-1:0] i_dm_wdata,
   input  logic [2:0]      i_dm_f3,
   input  logic            i_dm_lock,
   output logic            o_dm_ready,
   output logic [XLEN-1:0] o_dm_rdata,
   output logic            o_mem_req,
   output logic            o_mem_wen,
   output logic [XLEN-1:0] o_mem_addr,
   output logic [XLEN-1:0] o_mem_wdata,
   output logic [2:0]      o_mem_f3,
   input  logic            i_mem_ready,
   input  logic [XLEN-1:0] i_mem_rdata
);

   arb_state_t state;
   logic       last_grant;
   logic       lock_flag;
   logic       dm_req;
   logic       lock_hold;
   logic       gnt_ic;
   logic       gnt_dm;
   logic       ic_done;
   logic       dm_done;

   assign dm_req = i_dm_rd | i_dm_wr;

   // A set lock only survives IDLE while DM keeps asserting i_dm_lock;
   // dropping it reopens arbitration in the same cycle.
   assign lock_hold = lock_flag & i_dm_lock;

   rr_grant2 u_pick (
      .req_a  (i_ic_req),
      .req_b  (dm_req),
      .last   (last_grant),
      .lock_b (lock_hold),
      .gnt_a  (gnt_ic),
      .gnt_b  (gnt_dm)
   );

   assign ic_done = (state == ARB_IC) && i_mem_ready;
   assign dm_done = (state == ARB_DM) && i_mem_ready;

   always_comb begin
      o_ic_ready = ic_done;
      o_dm_ready = dm_done;
      o_ic_rdata = ic_done ? i_mem_rdata : '0;
      o_dm_rdata = dm_done ? i_mem_rdata : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state       <= ARB_IDLE;
         last_grant  <= RESET_LAST_DM;
         lock_flag   <= 1'b0;
         o_mem_req   <= 1'b0;
         o_mem_wen   <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_f3    <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (lock_flag && !i_dm_lock) begin
                  lock_flag <= 1'b0;
               end
               if (gnt_ic) begin
                  state       <= ARB_IC;
                  last_grant  <= 1'b0;
                  o_mem_req   <= 1'b1;
                  o_mem_wen   <= 1'b0;
                  o_mem_addr  <= i_ic_addr;
                  o_mem_wdata <= '0;
                  o_mem_f3    <= F3_WORD;
               end else if (gnt_dm) begin
                  state       <= ARB_DM;
                  last_grant  <= 1'b1;
                  o_mem_req   <= 1'b1;
                  o_mem_wen   <= i_dm_wr;
                  o_mem_addr  <= i_dm_addr;
                  o_mem_wdata <= i_dm_wdata;
                  o_mem_f3    <= i_dm_f3;
               end
            end
            ARB_IC: begin
               if (i_mem_ready) begin
                  state     <= ARB_IDLE;
                  o_mem_req <= 1'b0;
               end
            end
            ARB_DM: begin
               if (i_mem_ready) begin
                  state     <= ARB_IDLE;
                  o_mem_req <= 1'b0;
                  lock_flag <= i_dm_lock;
               end
            end
            default: begin
               state     <= ARB_IDLE;
               o_mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single accesses plus
// hand-written tie, atomic-lock, spurious-ready and mid-access reset sequences.
module tb_mem_port_arbiter;

   typedef struct {
      logic        dm;
      logic [31:0] addr;
      logic [2:0]  f3;
      logic        wen;
      logic [31:0] wdata;
   } grant_t;

   typedef struct {
      logic        dm;
      logic [31:0] rdata;
   } rdy_t;

   typedef struct {
      logic        ic;
      logic        dm_wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      int unsigned delay;
      logic [2:0]  exp_f3;
      logic [31:0] exp_rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ic_req = 1'b0;
   logic [31:0] ic_addr = '0;
   logic        dm_rd = 1'b0;
   logic        dm_wr = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [2:0]  dm_f3 = '0;
   logic        dm_lock = 1'b0;
   logic        model_ready = 1'b0;
   logic        spurious = 1'b0;
   logic        mem_ready;
   logic [31:0] mem_rdata = '0;

   logic        ic_ready, dm_ready, mem_req, mem_wen;
   logic [31:0] ic_rdata, dm_rdata, mem_addr, mem_wdata;
   logic [2:0]  mem_f3;

   grant_t      grant_q[$];
   rdy_t        ready_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          ready_count = 0;
   int unsigned mem_delay = 0;
   logic        prev_req = 1'b0;
   vec_t        vecs[5];

   assign mem_ready = model_ready | spurious;

   always #5 clk = ~clk;

   mem_port_arbiter #(.XLEN(32), .RESET_LAST_DM(1'b1)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_ic_req    (ic_req),
      .i_ic_addr   (ic_addr),
      .o_ic_ready  (ic_ready),
      .o_ic_rdata  (ic_rdata),
      .i_dm_rd     (dm_rd),
      .i_dm_wr     (dm_wr),
      .i_dm_addr   (dm_addr),
      .i_dm_wdata  (dm_wdata),
      .i_dm_f3     (dm_f3),
      .i_dm_lock   (dm_lock),
      .o_dm_ready  (dm_ready),
      .o_dm_rdata  (dm_rdata),
      .o_mem_req   (mem_req),
      .o_mem_wen   (mem_wen),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .o_mem_f3    (mem_f3),
      .i_mem_ready (mem_ready),
      .i_mem_rdata (mem_rdata)
   );

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h0000_0100) ? 32'h0000_0013 : ~a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic dm, input logic [31:0] addr, input logic [2:0] f3,
                           input logic wen, input logic [31:0] wdata, input logic [31:0] rdata);
      grant_q.push_back('{dm: dm, addr: addr, f3: f3, wen: wen, wdata: wdata});
      ready_q.push_back('{dm: dm, rdata: rdata});
   endtask

   task automatic wait_ready(input int target, input string name);
      for (int i = 0; i < 200; i++) begin
         if (ready_count >= target) break;
         @(negedge clk); #1;
      end
      chk(name, 32'(ready_count >= target), 32'd1);
   endtask

   task automatic wait_grant(input logic need_wen, input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (mem_req && (!need_wen || mem_wen)) begin
            seen = 1'b1;
            break;
         end
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      ic_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; dm_lock = 1'b0;
      grant_q.delete();
      ready_q.delete();
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int target;
      push_exp(!v.ic, v.addr, v.exp_f3, v.dm_wr, v.wdata, v.exp_rdata);
      target = ready_count + 1;
      mem_delay = v.delay;
      @(posedge clk); #2;
      if (v.ic) begin
         ic_req = 1'b1; ic_addr = v.addr;
      end else begin
         dm_rd = !v.dm_wr; dm_wr = v.dm_wr;
         dm_addr = v.addr; dm_wdata = v.wdata; dm_f3 = v.f3;
      end
      @(negedge clk);
      chk($sformatf("v%0d_req_before_grant", idx), 32'(mem_req), 32'd0);
      @(negedge clk); #1;
      chk($sformatf("v%0d_req_latency", idx), 32'(mem_req), 32'd1);
      for (int i = 0; i < 200; i++) begin
         if (ready_count >= target) break;
         if (v.dm_wr && mem_req) begin
            chk($sformatf("v%0d_wen_stable", idx), 32'(mem_wen), 32'd1);
            chk($sformatf("v%0d_wdata_stable", idx), mem_wdata, v.wdata);
            chk($sformatf("v%0d_addr_stable", idx), mem_addr, v.addr);
         end
         @(negedge clk); #1;
      end
      chk($sformatf("v%0d_ready_seen", idx), 32'(ready_count >= target), 32'd1);
      ic_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
      @(negedge clk); #1;
      chk($sformatf("v%0d_req_fall", idx), 32'(mem_req), 32'd0);
      chk($sformatf("v%0d_ready_single", idx), 32'(ic_ready | dm_ready), 32'd0);
      repeat (2) @(posedge clk);
   endtask

   // Memory model: answers a held request after mem_delay cycles with a
   // one-cycle ready strobe and address-derived data.
   initial begin
      int unsigned cnt;
      cnt = 0;
      forever begin
         @(posedge clk); #1;
         if (!rst) begin
            model_ready = 1'b0; mem_rdata = '0; cnt = 0;
         end else if (model_ready) begin
            model_ready = 1'b0; mem_rdata = '0; cnt = 0;
         end else if (mem_req) begin
            if (cnt >= mem_delay) begin
               model_ready = 1'b1;
               mem_rdata = mem_data(mem_addr);
            end else begin
               cnt++;
            end
         end
      end
   end

   always @(negedge clk) begin
      grant_t g;
      rdy_t   r;
      if (mem_req && !prev_req) begin
         if (grant_q.size() == 0) begin
            chk("unexpected_grant", mem_addr, 32'hFFFF_FFFF);
         end else begin
            g = grant_q.pop_front();
            chk("grant_addr", mem_addr, g.addr);
            chk("grant_f3", 32'(mem_f3), 32'(g.f3));
            chk("grant_wen", 32'(mem_wen), 32'(g.wen));
            if (g.wen) chk("grant_wdata", mem_wdata, g.wdata);
         end
      end
      prev_req = mem_req;
      if (ic_ready || dm_ready) begin
         ready_count++;
         chk("ready_exclusive", 32'(ic_ready & dm_ready), 32'd0);
         if (ready_q.size() == 0) begin
            chk("unexpected_ready", {30'd0, ic_ready, dm_ready}, 32'd0);
         end else begin
            r = ready_q.pop_front();
            chk("ready_side", 32'(dm_ready), 32'(r.dm));
            if (r.dm) chk("dm_rdata", dm_rdata, r.rdata);
            else      chk("ic_rdata", ic_rdata, r.rdata);
         end
      end
      if (!ic_ready) chk("ic_rdata_zero", ic_rdata, 32'd0);
      if (!dm_ready) chk("dm_rdata_zero", dm_rdata, 32'd0);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      vecs[0] = '{ic: 1'b1, dm_wr: 1'b0, addr: 32'h0000_0100, wdata: 32'h0, f3: 3'b000,
                  delay: 2, exp_f3: 3'b010, exp_rdata: 32'h0000_0013};
      vecs[1] = '{ic: 1'b0, dm_wr: 1'b0, addr: 32'h0000_8000, wdata: 32'h0, f3: 3'b100,
                  delay: 1, exp_f3: 3'b100, exp_rdata: 32'hFFFF_7FFF};
      vecs[2] = '{ic: 1'b0, dm_wr: 1'b1, addr: 32'h0000_8004, wdata: 32'hDEAD_BEEF, f3: 3'b010,
                  delay: 2, exp_f3: 3'b010, exp_rdata: 32'hFFFF_7FFB};
      vecs[3] = '{ic: 1'b1, dm_wr: 1'b0, addr: 32'h0000_3000, wdata: 32'h0, f3: 3'b000,
                  delay: 0, exp_f3: 3'b010, exp_rdata: 32'hFFFF_CFFF};
      vecs[4] = '{ic: 1'b0, dm_wr: 1'b0, addr: 32'h0000_8008, wdata: 32'h0, f3: 3'b001,
                  delay: 3, exp_f3: 3'b001, exp_rdata: 32'hFFFF_7FF7};

      do_reset();
      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_wen", 32'(mem_wen), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_f3", 32'(mem_f3), 32'd0);
      chk("rst_ready", 32'({ic_ready, dm_ready}), 32'd0);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // Tie from reset: IC first, then strict alternation.
      do_reset();
      mem_delay = 1;
      base = ready_count;
      for (int i = 0; i < 2; i++) begin
         push_exp(1'b0, 32'h0000_0200, 3'b010, 1'b0, 32'h0, mem_data(32'h0000_0200));
         push_exp(1'b1, 32'h0000_8000, 3'b010, 1'b0, 32'h0, mem_data(32'h0000_8000));
      end
      @(posedge clk); #2;
      ic_req = 1'b1; ic_addr = 32'h0000_0200;
      dm_rd = 1'b1; dm_addr = 32'h0000_8000; dm_f3 = 3'b010;
      wait_ready(base + 4, "tie_four_done");
      ic_req = 1'b0; dm_rd = 1'b0;
      repeat (3) @(posedge clk);
      chk("tie_queue_drained", 32'(grant_q.size()), 32'd0);

      // Atomic: locked DM read, then DM write; the waiting IC goes last.
      mem_delay = 1;
      base = ready_count;
      push_exp(1'b1, 32'h0000_8010, 3'b010, 1'b0, 32'h0, mem_data(32'h0000_8010));
      push_exp(1'b1, 32'h0000_8014, 3'b010, 1'b1, 32'h1234_5678, mem_data(32'h0000_8014));
      push_exp(1'b0, 32'h0000_0400, 3'b010, 1'b0, 32'h0, mem_data(32'h0000_0400));
      @(posedge clk); #2;
      dm_rd = 1'b1; dm_addr = 32'h0000_8010; dm_f3 = 3'b010; dm_lock = 1'b1;
      wait_grant(1'b0, "atomic_rd_grant");
      ic_req = 1'b1; ic_addr = 32'h0000_0400;
      wait_ready(base + 1, "atomic_rd_done");
      dm_rd = 1'b0; dm_wr = 1'b1; dm_addr = 32'h0000_8014; dm_wdata = 32'h1234_5678;
      wait_grant(1'b1, "atomic_wr_grant");
      dm_lock = 1'b0;
      wait_ready(base + 2, "atomic_wr_done");
      dm_wr = 1'b0;
      wait_ready(base + 3, "atomic_ic_done");
      ic_req = 1'b0;
      repeat (3) @(posedge clk);

      // Stray memory ready in IDLE must be ignored.
      base = ready_count;
      @(posedge clk); #2 spurious = 1'b1;
      @(negedge clk);
      chk("idle_ready_ic", 32'(ic_ready), 32'd0);
      chk("idle_ready_dm", 32'(dm_ready), 32'd0);
      @(posedge clk); #2 spurious = 1'b0;
      @(negedge clk);
      chk("idle_no_req", 32'(mem_req), 32'd0);
      chk("idle_no_strobe", 32'(ready_count), 32'(base));
      run_vec(vecs[3], 5);

      // Asynchronous reset in the middle of a DM access.
      mem_delay = 5;
      push_exp(1'b1, 32'h0000_8020, 3'b010, 1'b0, 32'h0, mem_data(32'h0000_8020));
      @(posedge clk); #2;
      dm_rd = 1'b1; dm_addr = 32'h0000_8020; dm_f3 = 3'b010;
      wait_grant(1'b0, "mid_rst_grant");
      @(posedge clk); #3;
      rst = 1'b0;
      dm_rd = 1'b0;
      grant_q.delete();
      ready_q.delete();
      #1;
      chk("mid_rst_req", 32'(mem_req), 32'd0);
      chk("mid_rst_addr", mem_addr, 32'd0);
      chk("mid_rst_f3", 32'(mem_f3), 32'd0);
      chk("mid_rst_ready", 32'({ic_ready, dm_ready}), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      mem_delay = 0;
      base = ready_count;
      push_exp(1'b0, 32'h0000_0500, 3'b010, 1'b0, 32'h0, mem_data(32'h0000_0500));
      @(posedge clk); #2;
      ic_req = 1'b1; ic_addr = 32'h0000_0500;
      dm_rd = 1'b1; dm_addr = 32'h0000_8030;
      wait_ready(base + 1, "post_rst_tie_done");
      ic_req = 1'b0; dm_rd = 1'b0;
      repeat (4) @(posedge clk);
      chk("post_rst_one_access", 32'(ready_count), 32'(base + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
